// File: rtl/tc_pkg.sv
// Shared constants and state encoding for the timing-channel stream reader.
package tc_pkg;

  localparam int unsigned FIELD_W        = 16;
  localparam int unsigned DIN_W          = 2 * FIELD_W;
  localparam int unsigned CNT_W          = 16;
  localparam int unsigned ALIGN_W        = 4;
  localparam int unsigned FRAME_LEN_DEF  = 1024;
  localparam int unsigned ALIGN_SKIP_DEF = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/tc_stream_reader.sv
// Reads packed {x0, x0z} words from a FIFO once it is read-enabled, drops the
// first ALIGN_SKIP words to absorb read latency, and frames the stream with
// sof/eof markers and a completed-frame counter.
module tc_stream_reader
  import tc_pkg::*;
#(
  parameter int unsigned FRAME_LEN  = FRAME_LEN_DEF,
  parameter int unsigned ALIGN_SKIP = ALIGN_SKIP_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIN_W-1:0]   fifo_tc_datain,
  input  logic               trigger_tc_ready_i,
  output logic [FIELD_W-1:0] x0_o,
  output logic [FIELD_W-1:0] x0z_o,
  output logic               data_valid_o,
  output logic               sof_o,
  output logic               eof_o,
  output logic [CNT_W-1:0]   frame_cnt_o,
  output logic               ready_lost_o
);

  localparam int unsigned        IDX_W    = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [ALIGN_W-1:0] SKIP_N   = ALIGN_W'(ALIGN_SKIP);

  state_e               r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [ALIGN_W-1:0]   r_align_cnt;
  logic [FIELD_W-1:0]   r_x0;
  logic [FIELD_W-1:0]   r_x0z;
  logic                 r_valid;
  logic                 r_sof;
  logic                 r_eof;
  logic [CNT_W-1:0]     r_frame_cnt;
  logic                 r_ready_lost;

  logic                 w_capture;
  logic                 w_last;

  assign w_last = (r_idx == LAST_IDX);

  // Decide whether this cycle's FIFO word is a real sample. The last
  // discarded-count cycle of ALIGN already carries valid data, and with no
  // skip the very cycle ready rises is the first sample.
  always_comb begin
    w_capture = 1'b0;
    if (trigger_tc_ready_i) begin
      case (r_state)
        ST_IDLE:  w_capture = (ALIGN_SKIP == 0);
        ST_ALIGN: w_capture = (r_align_cnt == SKIP_N);
        ST_RUN:   w_capture = 1'b1;
        default:  w_capture = 1'b0;
      endcase
    end
  end

  // State sequencing, sample capture, framing and the sticky ready-lost flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_align_cnt  <= '0;
      r_x0         <= '0;
      r_x0z        <= '0;
      r_valid      <= 1'b0;
      r_sof        <= 1'b0;
      r_eof        <= 1'b0;
      r_frame_cnt  <= '0;
      r_ready_lost <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (trigger_tc_ready_i) begin
            if (ALIGN_SKIP == 0) begin
              r_state <= ST_RUN;
            end else begin
              // The cycle ready rises is the first discarded word.
              r_state     <= ST_ALIGN;
              r_align_cnt <= ALIGN_W'(1);
            end
          end
        end
        ST_ALIGN: begin
          if (!trigger_tc_ready_i) begin
            r_state     <= ST_IDLE;
            r_align_cnt <= '0;
            r_idx       <= '0;
          end else if (r_align_cnt == SKIP_N) begin
            r_state     <= ST_RUN;
            r_align_cnt <= '0;
          end else begin
            r_align_cnt <= r_align_cnt + ALIGN_W'(1);
          end
        end
        ST_RUN: begin
          if (!trigger_tc_ready_i) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_ready_lost <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_idx       <= '0;
          r_align_cnt <= '0;
        end
      endcase

      if (w_capture) begin
        r_x0    <= fifo_tc_datain[DIN_W-1:FIELD_W];
        r_x0z   <= fifo_tc_datain[FIELD_W-1:0];
        r_valid <= 1'b1;
        r_sof   <= (r_idx == '0);
        r_eof   <= w_last;
        r_idx   <= w_last ? '0 : r_idx + IDX_W'(1);
        if (w_last) begin
          r_frame_cnt <= r_frame_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign x0_o         = r_x0;
  assign x0z_o        = r_x0z;
  assign data_valid_o = r_valid;
  assign sof_o        = r_sof;
  assign eof_o        = r_eof;
  assign frame_cnt_o  = r_frame_cnt;
  assign ready_lost_o = r_ready_lost;

endmodule

// File: tb/tb_tc_stream_reader.sv
// Bench for tc_stream_reader: two instances (FRAME_LEN=4/ALIGN_SKIP=1 and
// FRAME_LEN=2/ALIGN_SKIP=0) driven by directed and random steps and compared
// every cycle against a streak-based reference model.
module tb_tc_stream_reader;
  import tc_pkg::*;

  localparam int FL_A = 4;
  localparam int SK_A = 1;
  localparam int FL_B = 2;
  localparam int SK_B = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rdy_a, rst_b, rdy_b;
  logic [31:0] din_a, din_b;
  logic [15:0] x0_a, x0z_a, cnt_a, x0_b, x0z_b, cnt_b;
  logic        v_a, sof_a, eof_a, lost_a, v_b, sof_b, eof_b, lost_b;

  tc_stream_reader #(.FRAME_LEN(FL_A), .ALIGN_SKIP(SK_A)) u_a (
    .clk(clk), .rst(rst_a), .fifo_tc_datain(din_a), .trigger_tc_ready_i(rdy_a),
    .x0_o(x0_a), .x0z_o(x0z_a), .data_valid_o(v_a), .sof_o(sof_a), .eof_o(eof_a),
    .frame_cnt_o(cnt_a), .ready_lost_o(lost_a)
  );

  tc_stream_reader #(.FRAME_LEN(FL_B), .ALIGN_SKIP(SK_B)) u_b (
    .clk(clk), .rst(rst_b), .fifo_tc_datain(din_b), .trigger_tc_ready_i(rdy_b),
    .x0_o(x0_b), .x0z_o(x0z_b), .data_valid_o(v_b), .sof_o(sof_b), .eof_o(eof_b),
    .frame_cnt_o(cnt_b), .ready_lost_o(lost_b)
  );

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;

  // Reference model: per instance, the length of the current unbroken ready
  // streak decides everything (words 1..SKIP of a streak are dropped, word
  // SKIP+1+p is sample p of the stream).
  int          m_streak [2];
  logic [15:0] m_x0     [2];
  logic [15:0] m_x0z    [2];
  logic [15:0] m_cnt    [2];
  logic        m_v      [2];
  logic        m_sof    [2];
  logic        m_eof    [2];
  logic        m_lost   [2];

  function automatic int flen(input int k);
    return (k == 0) ? FL_A : FL_B;
  endfunction

  function automatic int fskip(input int k);
    return (k == 0) ? SK_A : SK_B;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[%0d] cycle=%0d observed=0x%0h expected=0x%0h", tag, k, cyc, obs, exp);
    end
  endtask

  task automatic model_edge(input int k, input logic r, input logic rdy, input logic [31:0] d);
    int p;
    int idx;
    if (r) begin
      m_streak[k] = 0;
      m_x0[k] = '0; m_x0z[k] = '0; m_cnt[k] = '0;
      m_v[k] = 1'b0; m_sof[k] = 1'b0; m_eof[k] = 1'b0; m_lost[k] = 1'b0;
    end else if (!rdy) begin
      if (m_streak[k] > fskip(k)) m_lost[k] = 1'b1;
      m_streak[k] = 0;
      m_v[k] = 1'b0; m_sof[k] = 1'b0; m_eof[k] = 1'b0;
    end else begin
      m_streak[k] = m_streak[k] + 1;
      if (m_streak[k] > fskip(k)) begin
        p   = m_streak[k] - fskip(k) - 1;
        idx = p % flen(k);
        m_v[k]   = 1'b1;
        m_x0[k]  = d[31:16];
        m_x0z[k] = d[15:0];
        m_sof[k] = (idx == 0);
        m_eof[k] = (idx == flen(k) - 1);
        if (m_eof[k]) m_cnt[k] = m_cnt[k] + 16'd1;
      end else begin
        m_v[k] = 1'b0; m_sof[k] = 1'b0; m_eof[k] = 1'b0;
      end
    end
  endtask

  task automatic check_all(input int k);
    logic [15:0] ox0, ox0z, ocnt;
    logic        ov, osof, oeof, olost;
    if (k == 0) begin
      ox0 = x0_a; ox0z = x0z_a; ocnt = cnt_a; ov = v_a; osof = sof_a; oeof = eof_a; olost = lost_a;
    end else begin
      ox0 = x0_b; ox0z = x0z_b; ocnt = cnt_b; ov = v_b; osof = sof_b; oeof = eof_b; olost = lost_b;
    end
    chk("model_x0", k, 32'(ox0), 32'(m_x0[k]));
    chk("model_x0z", k, 32'(ox0z), 32'(m_x0z[k]));
    chk("model_valid", k, 32'(ov), 32'(m_v[k]));
    chk("model_sof", k, 32'(osof), 32'(m_sof[k]));
    chk("model_eof", k, 32'(oeof), 32'(m_eof[k]));
    chk("model_frame_cnt", k, 32'(ocnt), 32'(m_cnt[k]));
    chk("model_ready_lost", k, 32'(olost), 32'(m_lost[k]));
  endtask

  // One clock: model consumes the inputs seen at the edge, outputs are
  // compared 1 time unit later.
  task automatic tick(input bit chk_a);
    @(posedge clk);
    model_edge(0, rst_a, rdy_a, din_a);
    model_edge(1, rst_b, rdy_b, din_b);
    #1;
    cyc++;
    if (chk_a) check_all(0);
    check_all(1);
  endtask

  logic [31:0] hold_b;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_streak[k] = 0; m_x0[k] = '0; m_x0z[k] = '0; m_cnt[k] = '0;
      m_v[k] = 1'b0; m_sof[k] = 1'b0; m_eof[k] = 1'b0; m_lost[k] = 1'b0;
    end
    rst_a = 1'b1; rst_b = 1'b1; rdy_a = 1'b0; rdy_b = 1'b0; din_a = '0; din_b = '0;

    // Cycles 0..2 in reset.
    for (int i = 0; i < 3; i++) tick(1'b1);
    chk("reset_valid", 0, 32'(v_a), 32'd0);
    chk("reset_frame_cnt", 0, 32'(cnt_a), 32'd0);
    chk("reset_x0", 0, 32'(x0_a), 32'd0);
    chk("reset_ready_lost", 1, 32'(lost_b), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;

    // Cycles 3,4 idle.
    tick(1'b1); tick(1'b1);

    // Cycle 5: ALIGN_SKIP=0 instance sees ready; data out at cycle 6.
    rdy_b = 1'b1; din_b = $urandom; hold_b = din_b;
    tick(1'b1);
    chk("skip0_valid", 1, 32'(v_b), 32'd1);
    chk("skip0_x0", 1, 32'(x0_b), 32'(hold_b[31:16]));
    chk("skip0_x0z", 1, 32'(x0z_b), 32'(hold_b[15:0]));
    chk("skip0_sof", 1, 32'(sof_b), 32'd1);
    rdy_b = 1'b0; din_b = $urandom;

    while (cyc < 10) tick(1'b1);

    // Cycle 10: ready rises; word 0 discarded, words 1..12 are samples 1..12.
    for (int j = 0; j < 13; j++) begin
      rdy_a = 1'b1;
      din_a = {16'(2 * j + 1), 16'(2 * j + 2)};
      tick(1'b1);
      if (j == 0) chk("align_discard_valid", 0, 32'(v_a), 32'd0);
      if (j == 1) begin
        chk("first_valid", 0, 32'(v_a), 32'd1);
        chk("first_x0", 0, 32'(x0_a), 32'h0003);
        chk("first_x0z", 0, 32'(x0z_a), 32'h0004);
        chk("first_sof", 0, 32'(sof_a), 32'd1);
      end
      if (j >= 1) begin
        chk("frame_eof", 0, 32'(eof_a), 32'(j % 4 == 0));
        chk("frame_cnt", 0, 32'(cnt_a), 32'(j / 4));
      end
    end

    // Two samples of a fourth frame, then ready drops.
    for (int j = 13; j < 15; j++) begin
      din_a = {16'(2 * j + 1), 16'(2 * j + 2)};
      tick(1'b1);
    end
    rdy_a = 1'b0; din_a = $urandom;
    tick(1'b1);
    chk("drop_ready_lost", 0, 32'(lost_a), 32'd1);
    chk("drop_valid", 0, 32'(v_a), 32'd0);
    chk("drop_frame_cnt", 0, 32'(cnt_a), 32'd3);
    tick(1'b1);
    chk("drop_lost_sticky", 0, 32'(lost_a), 32'd1);
    rdy_a = 1'b1; din_a = $urandom;
    tick(1'b1);
    chk("rearm_discard", 0, 32'(v_a), 32'd0);
    din_a = $urandom;
    tick(1'b1);
    chk("rearm_valid", 0, 32'(v_a), 32'd1);
    chk("rearm_sof", 0, 32'(sof_a), 32'd1);
    chk("rearm_frame_cnt", 0, 32'(cnt_a), 32'd3);
    chk("rearm_lost_sticky", 0, 32'(lost_a), 32'd1);

    // Sample index 1, then reset in the cycle that would carry index 2.
    din_a = $urandom;
    tick(1'b1);
    rst_a = 1'b1; din_a = $urandom;
    tick(1'b1);
    chk("rst_x0", 0, 32'(x0_a), 32'd0);
    chk("rst_x0z", 0, 32'(x0z_a), 32'd0);
    chk("rst_valid", 0, 32'(v_a), 32'd0);
    chk("rst_sof", 0, 32'(sof_a), 32'd0);
    chk("rst_eof", 0, 32'(eof_a), 32'd0);
    chk("rst_frame_cnt", 0, 32'(cnt_a), 32'd0);
    chk("rst_ready_lost", 0, 32'(lost_a), 32'd0);
    rst_a = 1'b0; din_a = $urandom;
    tick(1'b1);
    chk("rst_realign_discard", 0, 32'(v_a), 32'd0);
    din_a = $urandom;
    tick(1'b1);
    chk("rst_realign_sof", 0, 32'(sof_a), 32'd1);

    // Reset coinciding with a ready rise wins.
    rdy_a = 1'b0; tick(1'b1);
    rst_a = 1'b1; rdy_a = 1'b1; tick(1'b1);
    rst_a = 1'b0; din_a = $urandom; tick(1'b1);
    chk("rst_prio_discard", 0, 32'(v_a), 32'd0);
    din_a = $urandom; tick(1'b1);
    chk("rst_prio_sof", 0, 32'(sof_a), 32'd1);

    // Random traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      rdy_a = ($urandom_range(0, 99) < 85);
      rst_a = ($urandom_range(0, 99) < 2);
      din_a = $urandom;
      rdy_b = ($urandom_range(0, 99) < 85);
      rst_b = ($urandom_range(0, 99) < 2);
      din_b = $urandom;
      tick(1'b1);
    end

    // Frame counter wrap: 65535 two-sample frames, then one more.
    rst_a = 1'b0; rdy_a = 1'b0;
    rst_b = 1'b1; rdy_b = 1'b0;
    tick(1'b0);
    rst_b = 1'b0; rdy_b = 1'b1;
    for (int i = 0; i < 131070; i++) begin
      din_b = $urandom;
      tick(1'b0);
    end
    chk("wrap_preload_cnt", 1, 32'(cnt_b), 32'h0000FFFF);
    chk("wrap_preload_eof", 1, 32'(eof_b), 32'd1);
    din_b = $urandom; tick(1'b0);
    din_b = $urandom; tick(1'b0);
    chk("wrap_cnt", 1, 32'(cnt_b), 32'h00000000);
    chk("wrap_eof", 1, 32'(eof_b), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tc_stream_reader.md
TC_STREAM_READER -- requirements
Module: tc_stream_reader

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 1024, setting the samples per frame (legal range 2..8192).
REQ-002 The block SHALL have parameter ALIGN_SKIP, default 1, setting the cycles discarded after ready rises, to absorb FIFO read latency (legal range 0..15).
REQ-003 The block SHALL have port clk, input, 1, the single clock.
REQ-004 The block SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-005 The block SHALL have port fifo_tc_datain, input, 32, the FIFO read word {x0[31:16], x0z[15:0]}.
REQ-006 The block SHALL have port trigger_tc_ready_i, input, 1, the upstream FIFO read-enabled indication.
REQ-007 The block SHALL have port x0_o, output, 16, the unpacked upper field.
REQ-008 The block SHALL have port x0z_o, output, 16, the unpacked lower field.
REQ-009 The block SHALL have port data_valid_o, output, 1, qualifying x0_o/x0z_o.
REQ-010 The block SHALL have ports sof_o and eof_o, outputs, 1 each, marking the first and last sample of a frame; both are qualified by data_valid_o.
REQ-011 The block SHALL have port frame_cnt_o, output, 16, the count of completed frames.
REQ-012 The block SHALL have port ready_lost_o, output, 1, a sticky error flag set when ready is lost mid-stream.

Function
REQ-013 The block SHALL use a state machine with states IDLE, ALIGN and RUN.
REQ-014 In IDLE, the block SHALL move to ALIGN when trigger_tc_ready_i=1 and ALIGN_SKIP>0, or directly to RUN when ALIGN_SKIP=0.
REQ-015 In ALIGN, the block SHALL count ALIGN_SKIP cycles, counting the transition cycle as the first, discard the input, and then enter RUN.
REQ-016 In RUN, the block SHALL capture fifo_tc_datain every cycle and present x0_o=din[31:16], x0z_o=din[15:0] with data_valid_o=1 exactly one cycle later (registered, latency 1).
REQ-017 The block SHALL use a sample index 0..FRAME_LEN-1 that advances once per RUN cycle and wraps from FRAME_LEN-1 to 0.
REQ-018 The block SHALL assert sof_o with the sample at index 0 and eof_o with the sample at index FRAME_LEN-1; these are never both high for the same sample.
REQ-019 The block SHALL increment frame_cnt_o in the same cycle eof_o is output, wrapping from 0xFFFF to 0x0000.
REQ-020 If trigger_tc_ready_i=0 while in ALIGN or RUN, the block SHALL go to IDLE on the next edge, reset the sample index to 0, and not capture that cycle's input.
REQ-021 If trigger_tc_ready_i=0 while in RUN, the block SHALL also set ready_lost_o.
REQ-022 ready_lost_o SHALL remain set until rst.
REQ-023 A partial frame SHALL NOT increment frame_cnt_o.
REQ-024 After a ready drop, the next rise of trigger_tc_ready_i SHALL restart the ALIGN/RUN sequence, with the first output sample carrying sof_o=1.
REQ-025 When data_valid_o=0, the block SHALL drive sof_o and eof_o to 0 and hold x0_o and x0z_o at their last values.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL set the state to IDLE and clear the sample index and ALIGN counter.
REQ-027 When rst=1 at a clock edge, the block SHALL set x0_o=0, x0z_o=0, data_valid_o=0, sof_o=0, eof_o=0, frame_cnt_o=0 and ready_lost_o=0.
REQ-028 rst SHALL take priority over all other inputs, including a ready rise in the same cycle.
REQ-029 rst asserted mid-frame SHALL discard the frame, with no eof_o and no frame_cnt_o increment.

Structure
REQ-030 A shared package tc_pkg SHALL hold the state encoding constants, the field width constant (16) and the FRAME_LEN/ALIGN_SKIP defaults.
REQ-031 The design SHALL be a single module with no sub-module; the index and frame counters SHALL be inline.

Verification
REQ-032 The bench SHALL cover basic alignment. Stimulus: FRAME_LEN=4, ALIGN_SKIP=1; ready rises at cycle 10; din=0x00010002, 0x00030004, ... each cycle. Required response: the first valid output is at cycle 12, with x0_o=0x0003, x0z_o=0x0004, sof_o=1.
REQ-033 The bench SHALL cover frame framing. Stimulus: FRAME_LEN=4, ready held high for 12 RUN cycles. Required response: eof_o is high on samples 4, 8 and 12, and frame_cnt_o reads 1, 2 and 3.
REQ-034 The bench SHALL cover ready drop. Stimulus: ready drops after the 2nd RUN sample, then rises again. Required response: ready_lost_o=1 and stays 1, frame_cnt_o is unchanged, and the next valid sample has sof_o=1.
REQ-035 The bench SHALL cover ALIGN_SKIP=0. Stimulus: ready rises at cycle 5. Required response: a valid output at cycle 6 carrying the cycle-5 din.
REQ-036 The bench SHALL cover frame counter wrap. Stimulus: frame_cnt_o preloaded to 0xFFFF by running 65535 frames with FRAME_LEN=2, then one more frame. Required response: frame_cnt_o=0x0000.
REQ-037 The bench SHALL cover reset mid-frame. Stimulus: rst=1 for 1 cycle at index 2 while ready is high. Required response: all outputs are 0 the next cycle, the state is IDLE, and realignment restarts with sof_o=1.
